// File: rtl/uart_32_bit_pkg.sv
// Shared definitions for the 32-bit UART link (tx and rx sides).
// State encoding, default payload width and line levels.
package uart_32_bit_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_32_bit_tx_if.sv
// Handshake and line bundle between a word source and the UART transmitter.
// master drives the request side; slave is the transmitter.
interface uart_32_bit_tx_if
    import uart_32_bit_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  baud_tick;
    logic                  start;
    logic [DATA_WIDTH-1:0] data;
    logic                  tx;
    logic                  busy;
    logic                  done;

    modport master (
        output baud_tick, start, data,
        input  tx, busy, done
    );

    modport slave (
        input  baud_tick, start, data,
        output tx, busy, done
    );
endinterface

// File: rtl/uart_baud_tick_gen.sv
// Clock divider emitting a one-cycle baud_tick every DIVISOR clk cycles.
// Lives beside the tx/rx pair so both ends share one tick source.
module uart_baud_tick_gen #(
    parameter int DIVISOR = 16
) (
    input  logic clk,
    input  logic rst,
    output logic baud_tick
);
    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            baud_tick <= 1'b0;
        end else begin
            baud_tick <= (cnt == LAST);
            cnt       <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_32_bit_tx.sv
// UART transmitter: start bit, DATA_WIDTH bits LSB first, STOP_BITS stop bits; one bit per baud_tick.
// Accepts start only while idle (done cycle included); requests while busy are dropped, not queued.
module uart_32_bit_tx
    import uart_32_bit_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int STOP_BITS  = 1
) (
    input logic             clk,
    input logic             rst,
    uart_32_bit_tx_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_t           state;
    logic [DATA_WIDTH-1:0] shift;
    logic [CW-1:0]         bit_cnt;
    logic                  stop_cnt;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx_q     <= IDLE_LEVEL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q <= IDLE_LEVEL;
                    if (bus.start) begin
                        shift  <= bus.data;
                        busy_q <= 1'b1;
                        state  <= SYNC;
                    end
                end
                // Waiting a full tick here keeps the start bit one whole period wide.
                SYNC: begin
                    if (bus.baud_tick) begin
                        tx_q  <= START_LEVEL;
                        state <= START;
                    end
                end
                START: begin
                    if (bus.baud_tick) begin
                        tx_q    <= shift[0];
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bus.baud_tick) begin
                        if (bit_cnt != LAST_BIT) begin
                            shift   <= shift >> 1;
                            tx_q    <= shift[1];
                            bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            tx_q     <= STOP_LEVEL;
                            stop_cnt <= 1'b0;
                            state    <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (bus.baud_tick) begin
                        if (stop_cnt != LAST_STOP) begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end else begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_uart_32_bit_tx.sv
// Bench for uart_32_bit_tx: cycle-level line model plus a loopback frame decoder on a STOP_BITS=2 instance.
module tb_uart_32_bit_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tick_period = 4;
    int   tick_ctr    = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    uart_32_bit_tx_if #(.DATA_WIDTH(32)) bus ();
    uart_32_bit_tx_if #(.DATA_WIDTH(32)) bus2 ();

    uart_32_bit_tx #(.DATA_WIDTH(32), .STOP_BITS(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    uart_baud_tick_gen #(.DIVISOR(4)) tick_gen (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (bus2.baud_tick)
    );

    uart_32_bit_tx #(.DATA_WIDTH(32), .STOP_BITS(2)) dut_lb (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Tick source for the main instance; period 1 holds the tick high continuously.
    initial begin
        bus.baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick_ctr++;
            if (tick_ctr >= tick_period) begin
                tick_ctr      = 0;
                bus.baud_tick = 1'b1;
            end else begin
                bus.baud_tick = 1'b0;
            end
        end
    end

    // Reference model: an accepted word becomes a queue of line levels, one popped per tick.
    bit   m_q[$];
    logic m_tx   = 1'b1;
    logic m_busy = 1'b0;
    logic m_done = 1'b0;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (!rst) begin
            m_q.delete();
            m_tx   = 1'b1;
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (bus.start) begin
                m_q.delete();
                m_q.push_back(1'b0);
                for (int i = 0; i < 32; i++) m_q.push_back(bus.data[i]);
                m_q.push_back(1'b1);
                m_busy = 1'b1;
            end
        end else if (bus.baud_tick) begin
            if (m_q.size() != 0) begin
                m_tx = m_q.pop_front();
            end else begin
                m_tx   = 1'b1;
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    end

    int done_seen = 0;
    always @(negedge clk) begin
        check("tx", 32'(bus.tx), 32'(m_tx));
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("done", 32'(bus.done), 32'(m_done));
        if (bus.done) done_seen++;
    end

    // Loopback receiver: samples the line at each tick of the shared source.
    logic [31:0] rx_q[$];
    logic [31:0] rx_word = '0;
    int          rx_pos  = -1;
    int          lb_done = 0;

    always @(negedge clk) begin
        if (bus2.done) lb_done++;
        if (rst && bus2.baud_tick) begin
            if (rx_pos < 0) begin
                if (bus2.tx == 1'b0) rx_pos = 0;
            end else if (rx_pos < 32) begin
                rx_word[rx_pos] = bus2.tx;
                rx_pos++;
            end else begin
                check("lb_stop", 32'(bus2.tx), 32'd1);
                rx_pos++;
                if (rx_pos == 34) begin
                    rx_q.push_back(rx_word);
                    rx_pos = -1;
                end
            end
        end
    end

    task automatic send(input logic [31:0] d);
        @(negedge clk);
        bus.start = 1'b1;
        bus.data  = d;
        @(negedge clk);
        bus.start = 1'b0;
        bus.data  = $urandom();
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < budget);
        check(tag, 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_ticks(input int count, input int budget);
        int seen = 0;
        int n    = 0;
        while (seen < count && n < budget) begin
            @(negedge clk);
            n++;
            if (bus.baud_tick) seen++;
        end
        check("tick_wait", 32'(seen), 32'(count));
    endtask

    initial begin
        int n;
        int d0;
        bus.start  = 1'b0;
        bus.data   = '0;
        bus2.start = 1'b0;
        bus2.data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Single known frame.
        d0 = done_seen;
        send(32'hA5C3_0F96);
        wait_idle(400, "single_idle");
        check("single_done_cnt", 32'(done_seen - d0), 32'd1);

        // Request while busy is dropped.
        d0 = done_seen;
        send($urandom());
        wait_ticks(10, 200);
        @(negedge clk);
        bus.start = 1'b1;
        bus.data  = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(400, "busy_idle");
        repeat (40) @(negedge clk);
        check("busy_no_second", 32'(bus.busy), 32'd0);
        check("busy_done_cnt", 32'(done_seen - d0), 32'd1);

        // Back-to-back: start in the done cycle.
        send($urandom());
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 400);
        check("b2b_done_seen", 32'(bus.done), 32'd1);
        bus.start = 1'b1;
        bus.data  = 32'h0000_0001;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        wait_idle(400, "b2b_idle");

        // Start coincident with a tick: start bit waits a full period.
        n = 0;
        while (!bus.baud_tick && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.start = 1'b1;
        bus.data  = $urandom() | 32'h1;
        n = 0;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (bus.tx && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("coinc_sync_cycles", 32'(n), 32'(tick_period + 1));
        n = 0;
        while (!bus.tx && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("coinc_start_width", 32'(n), 32'(tick_period));
        wait_idle(400, "coinc_idle");

        // Reset during data bit 10.
        send($urandom());
        wait_ticks(12, 200);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        check("rst_quiet_busy", 32'(bus.busy), 32'd0);
        check("rst_quiet_tx", 32'(bus.tx), 32'd1);

        // Randomised frames, tick spacing and stray requests.
        for (int f = 0; f < 10; f++) begin
            tick_period = $urandom_range(1, 5);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send($urandom());
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 30)) @(negedge clk);
                bus.start = 1'b1;
                bus.data  = $urandom();
                @(negedge clk);
                bus.start = 1'b0;
            end
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 40)) @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
            wait_idle(400, "rand_idle");
        end

        // Loopback on the STOP_BITS=2 instance with the shared tick divider.
        tick_period = 4;
        lb_done = 0;
        foreach (rx_q[i]) rx_q.delete(i);
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            bus2.start = 1'b1;
            bus2.data  = (w == 0) ? 32'h0000_0000 : 32'hFFFF_FFFF;
            @(negedge clk);
            bus2.start = 1'b0;
            bus2.data  = 32'h5A5A_5A5A;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (bus2.busy && n < 400);
            check("lb_idle", 32'(bus2.busy), 32'd0);
        end
        repeat (20) @(negedge clk);
        check("lb_done_cnt", 32'(lb_done), 32'd2);
        check("lb_word_cnt", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() > 0) check("lb_word0", rx_q.pop_front(), 32'h0000_0000);
        if (rx_q.size() > 0) check("lb_word1", rx_q.pop_front(), 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_32_bit_tx.md
Name: uart_32_bit_tx

Overview:
Serial transmitter for the 32-bit UART link; the other end of uart_32_bit_rx.
- Accepts a 32-bit word on a one-cycle start strobe.
- Serialises it as one frame: 1 start bit (0), 32 data bits (data[0] first, data[31] last), STOP_BITS stop bits (1).
- Bit timing comes from an externally supplied baud_tick.
- The serial output is the line that feeds the receiver's rx input.

Parameters:
DATA_WIDTH, 32, payload bits per frame.
STOP_BITS, 1, stop bits per frame (legal values 1 or 2).

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
baud_tick  in  1  clk-synchronous enable; exactly one clk cycle high per bit period
start  in  1  request to send; sampled only while idle
data  in  DATA_WIDTH  payload; captured in the cycle start is accepted
tx  out  1  serial line; idle high
busy  out  1  high from the cycle after acceptance until the frame ends
done  out  1  one-cycle pulse when the last stop bit period completes

Behaviour:
- Reset (rst=0 at a clk edge) forces the following, from any state, mid-frame included:
  - state=IDLE, tx=1, busy=0, done=0, bit counter=0, shift register=0.
  - An in-flight frame is abandoned. The line simply returns high; no stop bit is appended.
- States: IDLE, SYNC, START, DATA, STOP.
- IDLE:
  - tx=1.
  - start=1 → latch data into the shift register, go to SYNC, busy=1 next cycle.
  - baud_tick is ignored in IDLE.
- SYNC:
  - tx stays 1.
  - On the next baud_tick → START, tx=0.
  - This aligns the start bit to a full tick period.
  - A baud_tick coincident with acceptance does not count.
- START:
  - On baud_tick → DATA, tx=shift[0], bit counter=0.
- DATA:
  - On each baud_tick:
    - If counter < DATA_WIDTH-1: shift right, tx=next bit, counter+1.
    - At counter = DATA_WIDTH-1: go to STOP, tx=1, stop counter=0.
- STOP:
  - On each baud_tick: if stop count < STOP_BITS-1, increment the stop count.
  - Otherwise → IDLE, busy=0 and done=1 in that same next cycle.
- tx is fully registered, with no combinational path from any input.
- Each bit is held exactly one baud_tick interval.
- Frame duration is (1+DATA_WIDTH+STOP_BITS) tick periods after SYNC, plus 0 to 1 tick periods of SYNC wait.
- done:
  - One cycle wide, coincident with the first IDLE cycle.
  - start may be asserted in that same cycle and is accepted (back-to-back frames allowed, no gap beyond the SYNC wait).
- start while busy=1: ignored, with no queueing; the data input is not re-sampled.
- Changing data after acceptance has no effect on the current frame.
- baud_tick held high for consecutive cycles violates the protocol; behaviour is defined as advancing one bit per high cycle, with no error flag.
- Counter widths: bit counter $clog2(DATA_WIDTH) bits; stop counter 1 bit.

Decomposition:
- Shared package uart_32_bit_pkg holds:
  - the state encoding (IDLE, SYNC, START, DATA, STOP);
  - DATA_WIDTH default;
  - line-level constants IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1.
- The package is reused by uart_32_bit_rx.
- Natural sub-module: uart_baud_tick_gen (clk divider producing the one-cycle baud_tick).
  - It is instantiated at the top level, not inside this block, so rx and tx share one tick source.
- The transmitter itself is a single module: FSM plus shift register plus counters.

Test Plan:
- Reset:
  - Hold rst=0 for 3 cycles mid-frame (during DATA bit 10).
  - Expect: tx=1, busy=0, done=0 on the next edge; no further line activity until a new start.
- Single frame:
  - start with data=32'hA5C3_0F96.
  - Expect: tx=1 until the first tick, then 0; then the bits of 0x96 LSB-first (0,1,1,0,1,0,0,1), then 0x0F, 0xC3, 0xA5 in order; then 1; done pulses once; busy low afterwards.
- Start while busy:
  - Assert start with data=32'hFFFF_FFFF during DATA.
  - Expect: the in-flight frame is unchanged, and no second frame follows.
- Back-to-back:
  - Assert start in the done cycle with data=32'h0000_0001.
  - Expect: the second frame begins at the next tick with start bit 0, then a data bit 1, then 31 zeros, then stop.
- Start coincident with baud_tick:
  - Expect: the start bit begins on the following tick, not the coincident one; all bit widths equal to one tick period.
- Loopback:
  - Connect tx→uart_32_bit_rx.rx, shared tick source, STOP_BITS=2.
  - Send 32'h0000_0000 then 32'hFFFF_FFFF.
  - Expect: the receiver's data output matches each word, and done fires exactly twice.
